// File: rtl/rr_grant_encoder_pkg.sv
// Shared constants, state encoding and the rotating-priority pick helper
// for the 8-requester round-robin grant encoder.
package rr_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    // First set bit at or after ptr, ascending with wrap; the offset sum wraps
    // naturally in IDX_W bits. Scanning farthest-first lets the nearest win.
    function automatic logic [IDX_W-1:0] rotate_pick(input logic [N_REQ-1:0] req,
                                                     input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        rotate_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                rotate_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between the requesters, the arbiter and binary_decoder.
interface rr_grant_encoder_if;
    import rr_pkg::*;

    logic [N_REQ-1:0] req;
    logic             out_ready;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] ptr;

    modport master (
        input  req,
        input  out_ready,
        output gnt_valid,
        output gnt_idx,
        output ptr
    );

    modport slave (
        output req,
        output out_ready,
        input  gnt_valid,
        input  gnt_idx,
        input  ptr
    );

endinterface

// File: rtl/rr_grant_encoder_pick.sv
// Combinational rotating-priority search; idx is only meaningful when any_req.
module rr_pick
    import rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    assign idx     = rotate_pick(req, ptr);
    assign any_req = |req;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter emitting a registered binary grant index under a
// valid/ready handshake, with back-to-back grants and a rotating pointer.
module rr_grant_encoder
    import rr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rr_grant_encoder_if.master bus
);

    state_t           state_q, state_nxt;
    logic             gnt_valid_q, gnt_valid_nxt;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_nxt;
    logic [IDX_W-1:0] ptr_q, ptr_nxt;

    logic             handshake;
    logic [IDX_W-1:0] after_gnt;
    logic [IDX_W-1:0] pick_base;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;

    assign handshake = (state_q == VALID) && bus.out_ready;
    assign after_gnt = gnt_idx_q + IDX_W'(1);
    // On acceptance the next search starts just past the winner, not at the old ptr.
    assign pick_base = handshake ? after_gnt : ptr_q;

    rr_pick u_pick (
        .req     (bus.req),
        .ptr     (pick_base),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_nxt     = state_q;
        gnt_valid_nxt = gnt_valid_q;
        gnt_idx_nxt   = gnt_idx_q;
        ptr_nxt       = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_idx_nxt   = pick_idx;
                    gnt_valid_nxt = 1'b1;
                    state_nxt     = VALID;
                end
            end
            VALID: begin
                if (bus.out_ready) begin
                    ptr_nxt = after_gnt;
                    if (any_req) begin
                        gnt_idx_nxt = pick_idx;
                    end else begin
                        gnt_valid_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                state_nxt     = IDLE;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_nxt;
            gnt_valid_q <= gnt_valid_nxt;
            gnt_idx_q   <= gnt_idx_nxt;
            ptr_q       <= ptr_nxt;
        end
    end

    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed plus random bench; committed grants are queued and popped by a
// monitor whenever the consumer accepts one.
module tb_rr_grant_encoder;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   started  = 0;

    logic [2:0] exp_q[$];
    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;

    rr_grant_encoder_if bus ();

    rr_grant_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // First requester at or after base, walking upward modulo 8.
    function automatic logic [2:0] m_pick(input logic [7:0] r, input logic [2:0] base);
        for (int off = 0; off < 8; off++) begin
            int i;
            i = (int'(base) + off) % 8;
            if (r[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // Apply inputs for one cycle, advance the model across that edge.
    task automatic step(input logic [7:0] r, input logic rd, input logic rs);
        logic       n_valid;
        logic [2:0] n_idx;
        logic [2:0] n_ptr;
        bus.req       = r;
        bus.out_ready = rd;
        rst           = rs;
        n_valid = m_valid;
        n_idx   = m_idx;
        n_ptr   = m_ptr;
        if (rs) begin
            exp_q   = {};
            n_valid = 1'b0;
            n_idx   = 3'd0;
            n_ptr   = 3'd0;
        end else if (!m_valid) begin
            if (r != 8'd0) begin
                n_idx   = m_pick(r, m_ptr);
                n_valid = 1'b1;
                exp_q.push_back(n_idx);
            end
        end else if (rd) begin
            n_ptr = 3'((int'(m_idx) + 1) % 8);
            if (r != 8'd0) begin
                n_idx = m_pick(r, n_ptr);
                exp_q.push_back(n_idx);
            end else begin
                n_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_idx   = n_idx;
        m_ptr   = n_ptr;
    endtask

    task automatic expect_now(input string name, input int v, input int idx, input int p);
        check({name, "_valid"}, int'(bus.gnt_valid), v);
        if (v != 0 || idx == 0) check({name, "_idx"}, int'(bus.gnt_idx), idx);
        check({name, "_ptr"}, int'(bus.ptr), p);
    endtask

    // Monitor: state tracking every cycle, scoreboard pop on each acceptance.
    always @(negedge clk) begin
        if (started) begin
            check("mon_valid", int'(bus.gnt_valid), int'(m_valid));
            check("mon_ptr", int'(bus.ptr), int'(m_ptr));
            if (bus.gnt_valid && bus.out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("sb_grant", int'(bus.gnt_idx), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        rst           = 1'b1;
        bus.req       = 8'd0;
        bus.out_ready = 1'b0;
        m_valid       = 1'b0;
        m_idx         = 3'd0;
        m_ptr         = 3'd0;

        // Reset held with all requesters active
        step(8'hFF, 1'b0, 1'b1);
        started = 1;
        expect_now("rst0", 0, 0, 0);
        step(8'hFF, 1'b0, 1'b1);
        expect_now("rst1", 0, 0, 0);
        step(8'hFF, 1'b0, 1'b0);
        expect_now("first_gnt", 1, 0, 0);

        // Hold and rotation
        step(8'h24, 1'b0, 1'b1);
        step(8'h24, 1'b0, 1'b0);
        expect_now("hold0", 1, 2, 0);
        step(8'h24, 1'b0, 1'b0);
        expect_now("hold1", 1, 2, 0);
        step(8'h24, 1'b0, 1'b0);
        expect_now("hold2", 1, 2, 0);
        step(8'h24, 1'b1, 1'b0);
        expect_now("rot5", 1, 5, 3);
        step(8'h24, 1'b1, 1'b0);
        expect_now("rot2", 1, 2, 6);

        // Wrap-around
        step(8'h81, 1'b1, 1'b0);
        expect_now("wrap7", 1, 7, 3);
        step(8'h81, 1'b1, 1'b0);
        expect_now("wrap0", 1, 0, 0);
        step(8'h20, 1'b1, 1'b0);
        expect_now("gnt5", 1, 5, 1);
        step(8'h00, 1'b1, 1'b0);
        expect_now("idle_p6", 0, 5, 6);
        step(8'h02, 1'b0, 1'b0);
        expect_now("wrap_p6", 1, 1, 6);

        // Back-to-back single requester, then idle exit
        step(8'h08, 1'b1, 1'b0);
        expect_now("b2b_first", 1, 3, 2);
        for (int i = 0; i < 4; i++) begin
            step(8'h08, 1'b1, 1'b0);
            expect_now("b2b", 1, 3, 4);
        end
        step(8'h00, 1'b1, 1'b0);
        expect_now("b2b_drop", 0, 3, 4);
        step(8'h00, 1'b1, 1'b0);
        expect_now("idle_ready_ignored", 0, 3, 4);

        // Committed grant ignores request changes
        step(8'h10, 1'b0, 1'b0);
        expect_now("commit4", 1, 4, 4);
        step(8'h01, 1'b0, 1'b0);
        expect_now("commit_hold", 1, 4, 4);
        step(8'h01, 1'b1, 1'b0);
        expect_now("commit_acc", 1, 0, 5);

        // Reset mid-handshake
        step(8'h02, 1'b1, 1'b0);
        expect_now("pre_rst1", 1, 1, 1);
        step(8'h40, 1'b1, 1'b0);
        expect_now("pre_rst6", 1, 6, 2);
        step(8'h40, 1'b1, 1'b1);
        expect_now("mid_rst", 0, 0, 0);
        step(8'hC0, 1'b0, 1'b0);
        expect_now("post_rst", 1, 6, 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'd0;
            step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
        end

        // Drain: every committed grant must have been accepted
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check("drain_valid", int'(bus.gnt_valid), 0);
        check("drain_queue", exp_q.size(), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
